// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch buffer.
// The fetch FSM states and the FIFO entry layout live here so both blocks agree.
package if_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DROP
    } if_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } if_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Synchronous DEPTH-entry queue of {pc, inst} pairs.
// Flush empties the queue and overrides any push or pop in the same cycle.
module if_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  if_entry_t                push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output if_entry_t                head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    if_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign do_push = push & ~flush & (count != FULL_CNT);
    assign do_pop  = pop & ~flush & (count != '0);
    assign head    = mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push & ~do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop & ~do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/if_fetch_buffer.sv
// Instruction fetch buffer: owns the fetch PC, keeps one read outstanding and
// queues returned words with their PCs for decode; redirects flush everything.
module if_fetch_buffer
    import if_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = if_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    if_state_e   state;
    if_state_e   state_nxt;
    logic [31:0] fetch_pc;
    logic [31:0] pend_pc;
    logic [AW:0] count;
    if_entry_t   head;
    if_entry_t   push_entry;
    logic        accept;
    logic        push;
    logic        pop;
    logic        unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];

    // Request is masked by reset so the port stays low while rst is held.
    assign imem_req   = (state == FETCH) & (count < FULL_CNT) & ~redirect & rst;
    assign imem_addr  = fetch_pc;
    assign accept     = imem_req & imem_gnt;

    assign push       = (state == WAIT) & imem_rvalid & ~redirect;
    assign push_entry = '{pc: pend_pc, inst: imem_rdata};

    assign inst_valid = (count != '0) & ~redirect;
    assign pop        = inst_valid & inst_ready;
    assign inst       = head.inst;
    assign inst_pc    = head.pc;

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH: if (accept) state_nxt = WAIT;
            WAIT: begin
                if (imem_rvalid) begin
                    state_nxt = FETCH;
                end else if (redirect) begin
                    state_nxt = DROP;
                end
            end
            DROP:    if (imem_rvalid) state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    // Redirect wins over the post-grant increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            pend_pc  <= '0;
        end else begin
            state <= state_nxt;
            if (redirect) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
            end else if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (accept) begin
                pend_pc <= fetch_pc;
            end
        end
    end

    if_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect),
        .count     (count),
        .head      (head)
    );

endmodule
